// File: rtl/apb_cmd_sequencer_if.sv
// Stream/bus bundle between a command producer, apb_cmd_sequencer and apb_master.
// The slave modport is the sequencer's view; the master modport is its environment's.
interface apb_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rw;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  start;
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  done;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_rw;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  busy;
    logic [CNT_W-1:0]      cmd_count;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, done, rdata, rsp_ready,
        output cmd_ready, start, rw, addr, wdata, rsp_valid, rsp_rw, rsp_addr, rsp_rdata,
               busy, cmd_count
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, done, rdata, rsp_ready,
        input  cmd_ready, start, rw, addr, wdata, rsp_valid, rsp_rw, rsp_addr, rsp_rdata,
               busy, cmd_count
    );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// Queues {rw, addr, wdata} commands and issues them one at a time to apb_master,
// returning each completion through a single held response slot.
module apb_cmd_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input logic                PCLK,
    input logic                PRESET,
    apb_cmd_sequencer_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2
    } state_t;

    state_t                r_state;
    logic [ENTRY_W-1:0]    r_mem [DEPTH];
    logic [PTR_W:0]        r_wptr;
    logic [PTR_W:0]        r_rptr;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_rw;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rsp_valid;
    logic                  r_rsp_rw;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                     (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_pop   = (r_state == StIdle) && !w_empty && (!r_rsp_valid || bus.rsp_ready);
    assign w_head  = r_mem[r_rptr[PTR_W-1:0]];

    always_ff @(posedge PCLK) begin
        if (w_push) begin
            r_mem[r_wptr[PTR_W-1:0]] <= {bus.cmd_rw, bus.cmd_addr, bus.cmd_wdata};
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state     <= StIdle;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rw    <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            // A response load in StWait below overrides this handshake clear.
            if (bus.rsp_ready) r_rsp_valid <= 1'b0;

            case (r_state)
                StIdle: begin
                    if (w_pop) begin
                        {r_rw, r_addr, r_wdata} <= w_head;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= StIssue;
                    end
                end
                StIssue: begin
                    r_start <= 1'b0;
                    r_state <= StWait;
                end
                StWait: begin
                    if (bus.done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rw    <= r_rw;
                        r_rsp_addr  <= r_addr;
                        r_rsp_rdata <= r_rw ? '0 : bus.rdata;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.cmd_ready = !w_full;
    assign bus.start     = r_start;
    assign bus.rw        = r_rw;
    assign bus.addr      = r_addr;
    assign bus.wdata     = r_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rw    = r_rsp_rw;
    assign bus.rsp_addr  = r_rsp_addr;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.busy      = r_busy;
    assign bus.cmd_count = r_wptr - r_rptr;
endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// Directed bench for apb_cmd_sequencer with a behavioural apb_master/memory stand-in.
module tb_apb_cmd_sequencer;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_cmd_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    apb_cmd_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Master stand-in: done two negedges after it sees start; writes return junk rdata.
    logic [DW-1:0] mem [256];
    int            m_cnt = 0;
    logic          m_done = 1'b0;
    logic          inj_done = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    assign bus.done  = m_done | inj_done;
    assign bus.rdata = m_rdata;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (rst) begin
                m_cnt = 0;
            end else if (m_cnt != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    if (bus.rw) begin
                        mem[bus.addr] = bus.wdata;
                        m_rdata = 32'hDEAD_BEEF;
                    end else begin
                        m_rdata = mem[bus.addr];
                    end
                end
            end else if (bus.start) begin
                m_cnt = 2;
            end
        end
    end

    // Edge monitor: records accepted responses and start pulses as the DUT samples them.
    logic [40:0] rsp_q[$];
    int          start_cnt = 0;
    int          start_long = 0;
    logic        prev_start = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && bus.rsp_valid && bus.rsp_ready)
                rsp_q.push_back({bus.rsp_rw, bus.rsp_addr, bus.rsp_rdata});
            if (bus.start) start_cnt++;
            if (bus.start && prev_start) start_long++;
            prev_start = bus.start;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        acc = bus.cmd_ready;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_wait(input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_rw    = rw;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("push_timeout", 64'(n), 64'd0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic rw, input logic [AW-1:0] a,
                              input logic [DW-1:0] d);
        int n = 0;
        logic [40:0] got;
        while (rsp_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() == 0) begin
            chk({tag, "_timeout"}, 64'd0, 64'd1);
        end else begin
            got = rsp_q.pop_front();
            chk(tag, 64'(got), 64'({rw, a, d}));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        chk({tag, "_start"}, 64'(bus.start), 64'd0);
        chk({tag, "_req"}, 64'({bus.rw, bus.addr, bus.wdata}), 64'd0);
        chk({tag, "_rsp"}, 64'({bus.rsp_valid, bus.rsp_rw, bus.rsp_addr, bus.rsp_rdata}), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_count"}, 64'(bus.cmd_count), 64'd0);
    endtask

    initial begin
        logic acc;
        int   s0;
        int   bad;
        logic          exp_rw [8];
        logic [AW-1:0] exp_a  [8];
        logic [DW-1:0] exp_d  [8];

        bus.cmd_valid = 1'b0;
        bus.cmd_rw    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset and idle behaviour
        repeat (2) @(negedge clk);
        chk_idle_outputs("in_reset");
        rst = 1'b0;
        start_cnt = 0;
        repeat (10) @(negedge clk);
        chk("idle_no_start", 64'(start_cnt), 64'd0);
        chk_idle_outputs("after_reset");

        // Write then read 0x10, checking pop latency
        bus.rsp_ready = 1'b1;
        start_cnt = 0;
        start_long = 0;
        push(1'b1, 8'h10, 32'hA5A5_A5A5, acc);
        chk("wr10_acc", 64'(acc), 64'd1);
        chk("lat_count_after_push", 64'(bus.cmd_count), 64'd1);
        chk("lat_no_start_yet", 64'(bus.start), 64'd0);
        @(negedge clk);
        chk("lat_start", 64'({bus.start, bus.busy}), 64'b11);
        chk("lat_req", 64'({bus.rw, bus.addr, bus.wdata}), 64'({1'b1, 8'h10, 32'hA5A5_A5A5}));
        chk("lat_count_after_pop", 64'(bus.cmd_count), 64'd0);
        push(1'b0, 8'h10, 32'h0, acc);
        chk("rd10_acc", 64'(acc), 64'd1);
        expect_rsp("rsp_wr10", 1'b1, 8'h10, 32'h0);
        expect_rsp("rsp_rd10", 1'b0, 8'h10, 32'hA5A5_A5A5);
        repeat (3) @(negedge clk);
        chk("two_starts", 64'(start_cnt), 64'd2);
        chk("start_single_cycle", 64'(start_long), 64'd0);

        // Spurious done while idle yields no response
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        chk("spurious_done", 64'({bus.rsp_valid, bus.busy}), 64'd0);
        chk("spurious_no_rsp", 64'(rsp_q.size()), 64'd0);

        // Full FIFO with the response slot held
        bus.rsp_ready = 1'b0;
        push(1'b1, 8'h30, 32'h0000_0030, acc);
        bad = 0;
        while (!bus.rsp_valid && bad < 50) begin
            @(negedge clk);
            bad++;
        end
        chk("held_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        s0 = start_cnt;
        for (int i = 0; i < 4; i++) begin
            push(1'b1, 8'(8'h34 + 4 * i), 32'(32'h100 + i), acc);
            chk("fill_acc", 64'(acc), 64'd1);
        end
        chk("full_count", 64'(bus.cmd_count), 64'd4);
        chk("full_not_ready", 64'(bus.cmd_ready), 64'd0);
        push(1'b1, 8'h44, 32'h999, acc);
        chk("fifth_refused", 64'(acc), 64'd0);
        chk("full_count_kept", 64'(bus.cmd_count), 64'd4);

        // Response backpressure holds the slot and blocks issue
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({bus.rsp_valid, bus.rsp_rw, bus.rsp_addr, bus.rsp_rdata} !==
                {1'b1, 1'b1, 8'h30, 32'h0}) bad++;
        end
        chk("bp_stable", 64'(bad), 64'd0);
        chk("bp_no_start", 64'(start_cnt - s0), 64'd0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop_same_edge", 64'({bus.start, bus.addr}), 64'({1'b1, 8'h34}));
        chk("bp_count", 64'(bus.cmd_count), 64'd3);
        chk("bp_rsp_cleared", 64'(bus.rsp_valid), 64'd0);
        expect_rsp("rsp_30", 1'b1, 8'h30, 32'h0);
        for (int i = 0; i < 4; i++) expect_rsp("rsp_fill", 1'b1, 8'(8'h34 + 4 * i), 32'h0);

        // Reset while a read of 0x20 is outstanding
        repeat (3) @(negedge clk);
        push(1'b0, 8'h20, 32'h0, acc);
        push(1'b0, 8'h24, 32'h0, acc);
        @(negedge clk);
        chk("pre_reset_wait", 64'({bus.busy, bus.start, bus.cmd_count}), 64'({2'b10, 3'd1}));
        rst = 1'b1;
        #1;
        chk("midwait_reset", 64'({bus.start, bus.busy, bus.rsp_valid, bus.cmd_count}), 64'd0);
        chk("midwait_ready", 64'(bus.cmd_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_wait(1'b1, 8'h04, 32'h1234_5678);
        push_wait(1'b0, 8'h04, 32'h0);
        expect_rsp("rsp_wr04", 1'b1, 8'h04, 32'h0);
        expect_rsp("rsp_rd04", 1'b0, 8'h04, 32'h1234_5678);

        // Ordering: four writes then four reads
        for (int i = 0; i < 4; i++) begin
            exp_rw[i]     = 1'b1;
            exp_a[i]      = 8'(4 * i);
            exp_d[i]      = 32'h0;
            exp_rw[i + 4] = 1'b0;
            exp_a[i + 4]  = 8'(4 * i);
            exp_d[i + 4]  = 32'(32'h11 * (i + 1));
        end
        for (int i = 0; i < 4; i++) push_wait(1'b1, exp_a[i], exp_d[i + 4]);
        for (int i = 4; i < 8; i++) push_wait(1'b0, exp_a[i], 32'h0);
        for (int i = 0; i < 8; i++) expect_rsp("order", exp_rw[i], exp_a[i], exp_d[i]);
        repeat (5) @(negedge clk);
        chk("order_no_extra", 64'(rsp_q.size()), 64'd0);
        chk("final_idle", 64'({bus.busy, bus.cmd_count}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
